ifq_param: RTL and testbench
============================

// Module: ifq_param
// PURPOSE
//  Parametrised instruction fetch queue between I-cache and dispatch of the RISC-V SP core.
//  Fetches whole cache lines (WORDS_PER_LINE x 32b), buffers up to DEPTH lines, hands out one
//  instruction+PC per pop. Adds branch/jump redirect with flush and mid-line start offset.
// PARAMETERS
//  DEPTH          4        line entries in queue (power of 2, >=2)
//  WORDS_PER_LINE 4        32-bit instructions per cache line (power of 2)
//  ADDR_W         32       PC width
//  RESET_PC       32'h0    first fetch address after reset
// PORTS
//  clk             in   1              rising-edge clock
//  rst_n           in   1              synchronous reset, active low
//  i_rd_en         in   1              dispatch pop request
//  o_instr         out  32             head instruction (valid when !o_empty)
//  o_pc            out  ADDR_W         PC of o_instr
//  o_empty         out  1              no instruction available
//  o_cache_rd_en   out  1              line request strobe, 1 cycle
//  o_cache_addr    out  ADDR_W         line-aligned request address
//  i_cache_line    in   32*WORDS_PER_LINE  returned line, word0 in LSBs
//  i_cache_valid   in   1              response for the single outstanding request
//  i_jmp_br_valid  in   1              redirect strobe
//  i_jmp_br_addr   in   ADDR_W         redirect target (word aligned)
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): queue empty, o_empty=1, o_instr=0, o_pc=0, o_cache_rd_en=0,
//   fetch_pc=RESET_PC, start offset 0, FSM=FETCH. Applies mid-operation; pending response dropped.
//  Entry = {line, line_pc, start_off}. Head word index = rd_off; rd_off loads start_off on pop-in.
//  o_instr = head.line[rd_off]; o_pc = head.line_pc + 4*rd_off; combinational from entry flops.
//  Pop: i_rd_en & !o_empty -> rd_off++; at rd_off==WORDS_PER_LINE-1 the entry retires, rd_ptr++.
//   i_rd_en while empty ignored. Pointers carry extra wrap bit; full = ptr MSBs differ, rest equal.
//  FSM: FETCH -> if count<DEPTH: o_cache_rd_en=1, o_cache_addr=fetch_pc, go WAIT.
//   WAIT -> on i_cache_valid: write entry, fetch_pc += 4*WORDS_PER_LINE, go FETCH.
//   DROP -> on i_cache_valid: discard line, go FETCH. One request outstanding max.
//  Latency: request cycle N, valid cycle M>=N+1, o_empty falls in cycle M+1 (queue was empty).
//  Redirect (highest priority): queue flushed next cycle, same-cycle pop and write suppressed,
//   fetch_pc = target & ~(line bytes-1), next written entry start_off = target word index.
//   Redirect in WAIT -> DROP (stale response discarded); in FETCH -> FETCH; repeat in DROP -> DROP.
//  Simultaneous pop-retire and write when full: write permitted only because request was issued
//   with count<DEPTH; never overflows. fetch_pc wraps modulo 2^ADDR_W.
// CONFIGURATION
//  IFQ_PERF_CNT_EN defined: adds outputs o_stall_cnt[31:0] (cycles i_rd_en=1 & o_empty=1) and
//   o_flush_cnt[31:0] (accepted redirects); both reset to 0, saturate at all-ones.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  ifq_pkg: entry struct typedef, fsm state enum {FETCH,WAIT,DROP}, LINE_BYTES/OFF_W localparams
//   derived from WORDS_PER_LINE. One sub-module ifq_line_ram (DEPTH x entry storage, 1W port,
//   async read at rd_ptr); pointers, FSM and offset logic in ifq_param.
// TESTING (bench preloads cache lines 0..3 = words 1..16, 1-cycle cache model)
//  1 Reset, i_rd_en=1 continuously -> o_instr 1,2,...,16 with o_pc 0x0,0x4,...,0x3C, no gaps after fill.
//  2 i_rd_en=0 -> exactly 4 requests (addr 0x0,0x10,0x20,0x30), then o_cache_rd_en stays 0; one pop
//    of 4 instrs frees entry -> request 0x40 issued.
//  3 Redirect to 0x18 while popping -> next o_instr=7 (pc 0x18), then 8, 9 (pc 0x20); old entries gone.
//  4 Redirect in WAIT with 3-cycle cache latency -> stale line discarded, first instr from new target.
//  5 rst_n low for one cycle with queue full -> o_empty=1 next cycle, refetch from RESET_PC.
//  6 IFQ_PERF_CNT_EN: 5 empty-stall cycles + 2 redirects -> o_stall_cnt=5, o_flush_cnt=2.

Source files
------------

// File: rtl/ifq_pkg.sv
// Shared types and geometry helpers for the instruction fetch queue.
package ifq_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  localparam int IFQ_DEF_WORDS  = 4;
  localparam int IFQ_DEF_ADDR_W = 32;

  function automatic int line_bytes(input int words);
    return 4 * words;
  endfunction

  function automatic int off_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  localparam int LINE_BYTES = line_bytes(IFQ_DEF_WORDS);
  localparam int OFF_W      = off_width(IFQ_DEF_WORDS);

  // Queue entry at the default geometry; the queue declares the same layout for its own parameters.
  typedef struct packed {
    logic [32*IFQ_DEF_WORDS-1:0] line;
    logic [IFQ_DEF_ADDR_W-1:0]   line_pc;
    logic [OFF_W-1:0]            start_off;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_line_ram.sv
// DEPTH x WIDTH entry storage: one synchronous write port, one asynchronous read port.
module ifq_line_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [WIDTH-1:0]         rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; the queue pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/ifq_param.sv
// Instruction fetch queue: whole-line fetch, DEPTH-line buffer, per-word pop, redirect with flush.
// Optional IFQ_PERF_CNT_EN adds saturating stall/flush counters.
module ifq_param
  import ifq_pkg::*;
#(
  parameter int               DEPTH          = 4,
  parameter int               WORDS_PER_LINE = 4,
  parameter int               ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] RESET_PC      = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_rd_en,
  output logic [31:0]                 o_instr,
  output logic [ADDR_W-1:0]           o_pc,
  output logic                        o_empty,
  output logic                        o_cache_rd_en,
  output logic [ADDR_W-1:0]           o_cache_addr,
  input  logic [32*WORDS_PER_LINE-1:0] i_cache_line,
  input  logic                        i_cache_valid,
  input  logic                        i_jmp_br_valid,
  input  logic [ADDR_W-1:0]           i_jmp_br_addr
`ifdef IFQ_PERF_CNT_EN
  ,
  output logic [31:0]                 o_stall_cnt,
  output logic [31:0]                 o_flush_cnt
`endif
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int LINE_B   = line_bytes(WORDS_PER_LINE);
  localparam int OFF_BITS = off_width(WORDS_PER_LINE);
  localparam logic [PTR_W:0]    DEPTH_C  = (PTR_W+1)'(DEPTH);
  localparam logic [OFF_BITS-1:0] LAST_OFF = OFF_BITS'(WORDS_PER_LINE - 1);

  typedef struct packed {
    logic [32*WORDS_PER_LINE-1:0] line;
    logic [ADDR_W-1:0]            line_pc;
    logic [OFF_BITS-1:0]          start_off;
  } entry_t;

  fetch_state_e        state_q, state_d;
  logic [PTR_W:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OFF_BITS-1:0] pop_cnt_q, pop_cnt_d;
  logic [OFF_BITS-1:0] start_off_q, start_off_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic                req_q, req_d;

  entry_t              wr_entry, head;
  logic [PTR_W:0]      count;
  logic [OFF_BITS-1:0] rd_off;
  logic                empty, do_pop, do_retire, do_write;

  assign count     = wr_ptr_q - rd_ptr_q;
  assign empty     = (wr_ptr_q == rd_ptr_q);
  // Head word index = entry start offset plus words already popped from it.
  assign rd_off    = head.start_off + pop_cnt_q;
  assign do_pop    = i_rd_en & ~empty & ~i_jmp_br_valid;
  assign do_retire = do_pop & (rd_off == LAST_OFF);
  assign do_write  = (state_q == WAIT) & i_cache_valid & ~i_jmp_br_valid;

  assign wr_entry.line      = i_cache_line;
  assign wr_entry.line_pc   = fetch_pc_q;
  assign wr_entry.start_off = start_off_q;

  ifq_line_ram #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_line_ram (
    .clk       (clk),
    .wr_en_i   (do_write),
    .wr_addr_i (wr_ptr_q[PTR_W-1:0]),
    .wr_data_i (wr_entry),
    .rd_addr_i (rd_ptr_q[PTR_W-1:0]),
    .rd_data_o (head)
  );

  assign o_empty       = empty;
  assign o_instr       = empty ? '0 : head.line[{rd_off, 5'b0} +: 32];
  assign o_pc          = empty ? '0 : head.line_pc + ADDR_W'({rd_off, 2'b00});
  assign o_cache_rd_en = req_q;
  assign o_cache_addr  = fetch_pc_q;

  // NOTE: every always_comb output gets a default first so no path leaves it holding state (no latch).
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pop_cnt_d   = pop_cnt_q;
    start_off_d = start_off_q;
    fetch_pc_d  = fetch_pc_q;
    req_d       = 1'b0;

    if (do_pop) begin
      if (do_retire) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        pop_cnt_d = '0;
      end else begin
        pop_cnt_d = pop_cnt_q + 1'b1;
      end
    end

    if (do_write) begin
      wr_ptr_d    = wr_ptr_q + 1'b1;
      fetch_pc_d  = fetch_pc_q + ADDR_W'(LINE_B);
      start_off_d = '0;
    end

    // A response arriving together with a redirect still closes the outstanding request.
    unique case (state_q)
      FETCH: if (!i_jmp_br_valid && count < DEPTH_C) begin
        req_d   = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (i_cache_valid)       state_d = FETCH;
        else if (i_jmp_br_valid) state_d = DROP;
      end
      DROP:    if (i_cache_valid) state_d = FETCH;
      default: state_d = FETCH;
    endcase

    if (i_jmp_br_valid) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      pop_cnt_d   = '0;
      fetch_pc_d  = i_jmp_br_addr & ~ADDR_W'(LINE_B - 1);
      start_off_d = (WORDS_PER_LINE > 1) ? i_jmp_br_addr[2 +: OFF_BITS] : '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pop_cnt_q   <= '0;
      start_off_q <= '0;
      fetch_pc_q  <= RESET_PC;
      req_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pop_cnt_q   <= pop_cnt_d;
      start_off_q <= start_off_d;
      fetch_pc_q  <= fetch_pc_d;
      req_q       <= req_d;
    end
  end

`ifdef IFQ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (i_rd_en && empty && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (i_jmp_br_valid && flush_cnt_q != '1)  flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ifq_param.sv
// Directed bench for ifq_param with a variable-latency cache model; word at address A is A/4+1.
module tb_ifq_param;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_rd_en;
  logic [31:0]   o_instr;
  logic [31:0]   o_pc;
  logic          o_empty;
  logic          o_cache_rd_en;
  logic [31:0]   o_cache_addr;
  logic [127:0]  i_cache_line;
  logic          i_cache_valid;
  logic          i_jmp_br_valid;
  logic [31:0]   i_jmp_br_addr;
`ifdef IFQ_PERF_CNT_EN
  logic [31:0]   o_stall_cnt;
  logic [31:0]   o_flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int lat      = 1;

  ifq_param #(
    .DEPTH          (4),
    .WORDS_PER_LINE (4),
    .ADDR_W         (32),
    .RESET_PC       (32'h0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_rd_en        (i_rd_en),
    .o_instr        (o_instr),
    .o_pc           (o_pc),
    .o_empty        (o_empty),
    .o_cache_rd_en  (o_cache_rd_en),
    .o_cache_addr   (o_cache_addr),
    .i_cache_line   (i_cache_line),
    .i_cache_valid  (i_cache_valid),
    .i_jmp_br_valid (i_jmp_br_valid),
    .i_jmp_br_addr  (i_jmp_br_addr)
`ifdef IFQ_PERF_CNT_EN
    ,
    .o_stall_cnt    (o_stall_cnt),
    .o_flush_cnt    (o_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] mk_line(input logic [31:0] addr);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[32*w +: 32] = (addr >> 2) + 32'(w) + 32'd1;
    return l;
  endfunction

  // Cache model: a request seen in cycle N is answered with a 1-cycle valid in cycle N+lat.
  initial begin : cache_model
    logic        m_pend;
    int          m_cnt;
    logic [31:0] m_addr;
    m_pend = 1'b0;
    m_cnt  = 0;
    m_addr = '0;
    i_cache_valid = 1'b0;
    i_cache_line  = '0;
    forever begin
      @(posedge clk);
      #1;
      i_cache_valid = 1'b0;
      if (m_pend) begin
        m_cnt--;
        if (m_cnt == 0) begin
          i_cache_valid = 1'b1;
          i_cache_line  = mk_line(m_addr);
          m_pend        = 1'b0;
        end
      end
      @(negedge clk);
      if (!rst_n) m_pend = 1'b0;
      else if (o_cache_rd_en) begin
        m_pend = 1'b1;
        m_cnt  = lat;
        m_addr = o_cache_addr;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One reset edge; returns at the start of the first cycle after it.
  task automatic do_reset();
    i_jmp_br_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] target);
    tick();
    i_jmp_br_valid = 1'b1;
    i_jmp_br_addr  = target;
    tick();
    i_jmp_br_valid = 1'b0;
  endtask

  // With i_rd_en held high, every non-empty cycle is one pop: check the next one.
  task automatic pop_check(input logic [31:0] exp_instr, input logic [31:0] exp_pc,
                           input string tag, output int waited);
    waited = 0;
    @(negedge clk);
    while (o_empty && waited < 40) begin
      waited++;
      @(negedge clk);
    end
    check({tag, "_instr"}, 64'(o_instr), 64'(exp_instr));
    check({tag, "_pc"}, 64'(o_pc), 64'(exp_pc));
  endtask

  task automatic wait_req(input logic [31:0] exp_addr, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_cache_rd_en && n < 40) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_rd_en"}, 64'(o_cache_rd_en), 64'd1);
    check({tag, "_addr"}, 64'(o_cache_addr), 64'(exp_addr));
  endtask

  initial begin : stimulus
    int w;
    int nreq;
    rst_n          = 1'b0;
    i_rd_en        = 1'b0;
    i_jmp_br_valid = 1'b0;
    i_jmp_br_addr  = '0;

    // 1: reset state, then continuous popping yields 1..16 without gaps once filled
    lat     = 1;
    i_rd_en = 1'b1;
    do_reset();
    @(negedge clk);
    check("rst_empty", 64'(o_empty), 64'd1);
    check("rst_instr", 64'(o_instr), 64'd0);
    check("rst_pc", 64'(o_pc), 64'd0);
    check("rst_rd_en", 64'(o_cache_rd_en), 64'd0);
`ifdef IFQ_PERF_CNT_EN
    check("rst_stall_cnt", 64'(o_stall_cnt), 64'd0);
    check("rst_flush_cnt", 64'(o_flush_cnt), 64'd0);
`endif
    for (int i = 0; i < 16; i++) begin
      pop_check(32'(i + 1), 32'(4 * i), "t1_pop", w);
      if (i > 0) check("t1_no_gap", 64'(w), 64'd0);
    end

    // 2: no pops -> exactly four line requests, then one freed entry triggers 0x40
    i_rd_en = 1'b0;
    do_reset();
    nreq = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (o_cache_rd_en) begin
        check("t2_req_addr", 64'(o_cache_addr), 64'(16 * nreq));
        nreq++;
      end
    end
    check("t2_req_count", 64'(nreq), 64'd4);
    tick();
    i_rd_en = 1'b1;
    for (int i = 0; i < 4; i++) pop_check(32'(i + 1), 32'(4 * i), "t2_pop", w);
    tick();
    i_rd_en = 1'b0;
    wait_req(32'h40, "t2_refill");

    // 5: reset while full -> empty next cycle, refetch from RESET_PC
    repeat (3) tick();
    @(negedge clk);
    check("t5_full_no_req", 64'(o_cache_rd_en), 64'd0);
    check("t5_full_not_empty", 64'(o_empty), 64'd0);
    do_reset();
    @(negedge clk);
    check("t5_empty", 64'(o_empty), 64'd1);
    check("t5_instr", 64'(o_instr), 64'd0);
    check("t5_pc", 64'(o_pc), 64'd0);
    wait_req(32'h0, "t5_refetch");
    tick();
    i_rd_en = 1'b1;
    pop_check(32'd1, 32'h0, "t5_pop", w);
    tick();
    i_rd_en = 1'b0;

    // 3: redirect to 0x18 while popping -> 7 (0x18), 8, then 9 (0x20)
    lat     = 1;
    i_rd_en = 1'b1;
    do_reset();
    pop_check(32'd1, 32'h0, "t3_pre", w);
    pop_check(32'd2, 32'h4, "t3_pre", w);
    redirect(32'h18);
    @(negedge clk);
    check("t3_flushed", 64'(o_empty), 64'd1);
    pop_check(32'd7, 32'h18, "t3_pop7", w);
    pop_check(32'd8, 32'h1C, "t3_pop8", w);
    pop_check(32'd9, 32'h20, "t3_pop9", w);
    i_rd_en = 1'b0;

    // 4: redirect while waiting on a 3-cycle response -> stale line dropped
    lat = 3;
    do_reset();
    @(negedge clk);
    wait_req(32'h0, "t4_first_req");
    redirect(32'h24);
    wait_req(32'h20, "t4_new_req");
    check("t4_stale_dropped", 64'(o_empty), 64'd1);
    tick();
    i_rd_en = 1'b1;
    pop_check(32'd10, 32'h24, "t4_pop10", w);
    pop_check(32'd11, 32'h28, "t4_pop11", w);
    tick();
    i_rd_en = 1'b0;

`ifdef IFQ_PERF_CNT_EN
    // 6: five empty-stall cycles, then two redirects
    lat = 3;
    do_reset();
    i_rd_en = 1'b1;
    repeat (5) tick();
    i_rd_en = 1'b0;
    @(negedge clk);
    check("t6_stall_cnt", 64'(o_stall_cnt), 64'd5);
    check("t6_flush_cnt_pre", 64'(o_flush_cnt), 64'd0);
    redirect(32'h40);
    redirect(32'h80);
    @(negedge clk);
    check("t6_flush_cnt", 64'(o_flush_cnt), 64'd2);
    check("t6_stall_hold", 64'(o_stall_cnt), 64'd5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
